icache_responder: RTL and testbench

- Direct-mapped instruction cache that answers the datapath's instruction-fetch requests: imemREN/imemaddr in, ihit/imemload out.
- On a miss it fetches the word from the memory side through a single-word request/wait handshake (iREN/iaddr/iwait/iload).
- Sits between the pipeline's fetch stage and the memory controller.
- A hit returns the instruction combinationally in the same cycle.

---
 rtl/icache_responder_if.sv | 26 ++
 rtl/icache_responder.sv | 95 +++++++++
 tb/tb_icache_responder.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_responder_if.sv
// Fetch-side and memory-side signals of the direct-mapped instruction cache.
// The slave modport is the cache; the master modport is whoever drives fetches and memory.
interface icache_responder_if #(
  parameter int unsigned WORD_W = 32
);
  logic              imemREN;
  logic [WORD_W-1:0] imemaddr;
  logic              ihit;
  logic [WORD_W-1:0] imemload;
  logic              flush;
  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic              iwait;
  logic [WORD_W-1:0] iload;
  logic [WORD_W-1:0] miss_count;

  modport slave (
    input  imemREN, imemaddr, flush, iwait, iload,
    output ihit, imemload, iREN, iaddr, miss_count
  );

  modport master (
    output imemREN, imemaddr, flush, iwait, iload,
    input  ihit, imemload, iREN, iaddr, miss_count
  );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped one-word-per-frame instruction cache: combinational hit path,
// single-word fill from memory on a miss.
module icache_responder #(
  parameter int unsigned SETS   = 16,
  parameter int unsigned WORD_W = 32
) (
  input logic               CLK,
  input logic               RST,
  icache_responder_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = WORD_W - IDX_W - 2;

  typedef enum logic [0:0] {StIdle, StFetch} state_e;

  state_e            state_q;
  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [WORD_W-1:0] data_q [SETS];
  logic [WORD_W-3:0] miss_addr_q;
  logic              iren_q;
  logic [WORD_W-1:0] miss_count_q;

  logic [IDX_W-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0] req_tag, fill_tag;
  logic             hit;
  logic             fill_we;
  logic [1:0]       unused_addr_lsb;

  assign req_idx         = bus.imemaddr[IDX_W+1:2];
  assign req_tag         = bus.imemaddr[WORD_W-1:IDX_W+2];
  assign fill_idx        = miss_addr_q[IDX_W-1:0];
  assign fill_tag        = miss_addr_q[WORD_W-3:IDX_W];
  assign unused_addr_lsb = bus.imemaddr[1:0];

  always_comb begin
    hit          = bus.imemREN & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
    bus.ihit     = hit & ~bus.flush;
    bus.imemload = hit ? data_q[req_idx] : '0;
    // flush outranks a completing fill
    fill_we      = (state_q == StFetch) & ~bus.flush & ~bus.iwait;
  end

  assign bus.iREN       = iren_q;
  assign bus.iaddr      = {miss_addr_q, 2'b00};
  assign bus.miss_count = miss_count_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= StIdle;
      valid_q      <= '0;
      miss_addr_q  <= '0;
      iren_q       <= 1'b0;
      miss_count_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.flush) begin
            valid_q <= '0;
          end else if (bus.imemREN && !hit) begin
            miss_addr_q <= bus.imemaddr[WORD_W-1:2];
            iren_q      <= 1'b1;
            state_q     <= StFetch;
          end
        end
        StFetch: begin
          if (bus.flush) begin
            valid_q <= '0;
            iren_q  <= 1'b0;
            state_q <= StIdle;
          end else if (!bus.iwait) begin
            valid_q[fill_idx] <= 1'b1;
            if (miss_count_q != '1) begin
              miss_count_q <= miss_count_q + WORD_W'(1);
            end
            iren_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          iren_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Tag/data arrays carry no reset; valid_q alone qualifies them.
  always_ff @(posedge CLK) begin
    if (fill_we) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= bus.iload;
    end
  end
endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench for icache_responder: directed scenarios plus randomized
// fetch streams compared against an array-based cache model and a memory function.
module tb_icache_responder;
  logic clk;
  logic rst;
  int   vectors;
  int   errors;
  int   lat;
  int   busy_cnt;
  int   exp_count;

  logic        mv  [16];
  logic [29:0] mwa [16];

  icache_responder_if #(.WORD_W(32)) bus ();

  icache_responder #(.SETS(16), .WORD_W(32)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[31:2], 2'b00} * 32'h0001_0003 + 32'h2001_0005;
  endfunction

  // Memory: stays busy for lat cycles of each request, then answers.
  always @(posedge clk or posedge rst) begin
    if (rst) busy_cnt <= 0;
    else if (!bus.iREN || !bus.iwait) busy_cnt <= 0;
    else busy_cnt <= busy_cnt + 1;
  end
  assign bus.iwait = bus.iREN && (busy_cnt < lat);
  assign bus.iload = mem_fn(bus.iaddr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model_hit(input logic [31:0] a);
    return mv[a[5:2]] && (mwa[a[5:2]] == a[31:2]);
  endfunction

  task automatic model_fill(input logic [31:0] a);
    mv[a[5:2]]  = 1'b1;
    mwa[a[5:2]] = a[31:2];
    exp_count++;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.flush    = 1'b0;
    bus.imemREN  = 1'b0;
    bus.imemaddr = '0;
    lat          = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
    exp_count = 0;
  endtask

  // Drive one fetch and report what was observed; callers do the comparing.
  task automatic run_fetch(input logic [31:0] addr, input int l, output logic h0,
                           output logic [31:0] d0, output int ncyc, output logic addr_ok,
                           output logic h1, output logic [31:0] d1);
    @(negedge clk);
    bus.imemREN  = 1'b1;
    bus.imemaddr = addr;
    lat          = l;
    #1;
    h0 = bus.ihit; d0 = bus.imemload;
    ncyc = 0; addr_ok = 1'b1; h1 = h0; d1 = d0;
    if (!h0) begin
      for (int c = 0; c < 40; c++) begin
        @(negedge clk); #1;
        if (!bus.iREN) break;
        ncyc++;
        if (bus.iaddr !== {addr[31:2], 2'b00}) addr_ok = 1'b0;
      end
      h1 = bus.ihit; d1 = bus.imemload;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.flush = 1'b0;
    @(negedge clk);
    bus.imemREN = 1'b1; bus.imemaddr = 32'h0;
    #1;
    vectors++;
    if (bus.iREN !== 1'b0) begin errors++; $display("FAIL reset_iren: got %b want 0", bus.iREN); end
    vectors++;
    if (bus.iaddr !== 32'h0) begin errors++; $display("FAIL reset_iaddr: got %h want 0", bus.iaddr); end
    vectors++;
    if (bus.miss_count !== 32'h0) begin
      errors++; $display("FAIL reset_count: got %0d want 0", bus.miss_count);
    end
    vectors++;
    if (bus.ihit !== 1'b0 || bus.imemload !== 32'h0) begin
      errors++; $display("FAIL reset_hit: got %b/%h want 0/0", bus.ihit, bus.imemload);
    end
    do_reset();
  endtask

  task automatic test_miss_latency();
    logic h0, h1, ok; logic [31:0] d0, d1; int n;
    do_reset();
    run_fetch(32'h0, 3, h0, d0, n, ok, h1, d1);
    vectors++;
    if (h0 !== 1'b0) begin errors++; $display("FAIL lat_first_hit: got %b want 0", h0); end
    vectors++;
    if (n != 4 || !ok) begin errors++; $display("FAIL lat_iren: got %0d cycles ok=%b want 4 ok=1", n, ok); end
    vectors++;
    if (h1 !== 1'b1 || d1 !== 32'h2001_0005) begin
      errors++; $display("FAIL lat_hit: got %b/%h want 1/20010005", h1, d1);
    end
    vectors++;
    if (bus.miss_count !== 32'd1) begin
      errors++; $display("FAIL lat_count: got %0d want 1", bus.miss_count);
    end
  endtask

  task automatic test_sequential();
    logic h0, h1, ok; logic [31:0] d0, d1; int n; logic [31:0] a;
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 3; i++) begin
        a = 32'(i * 4);
        run_fetch(a, 0, h0, d0, n, ok, h1, d1);
        vectors++;
        if (h0 !== (pass == 1)) begin
          errors++; $display("FAIL seq_hit p%0d a=%h: got %b want %b", pass, a, h0, pass == 1);
        end
        vectors++;
        if (pass == 1 && (bus.iREN !== 1'b0 || d0 !== mem_fn(a))) begin
          errors++; $display("FAIL seq_data a=%h: got %h iren=%b want %h iren=0", a, d0, bus.iREN,
                             mem_fn(a));
        end
        vectors++;
        if (pass == 0 && (n != 1 || !ok || h1 !== 1'b1 || d1 !== mem_fn(a))) begin
          errors++; $display("FAIL seq_fill a=%h: got n=%0d ok=%b %b/%h want 1/1/1/%h", a, n, ok,
                             h1, d1, mem_fn(a));
        end
      end
    end
    vectors++;
    if (bus.miss_count !== 32'd3) begin
      errors++; $display("FAIL seq_count: got %0d want 3", bus.miss_count);
    end
  endtask

  task automatic test_conflict();
    logic h0, h1, ok; logic [31:0] d0, d1; int n;
    logic [31:0] seq [3];
    seq[0] = 32'h04; seq[1] = 32'h44; seq[2] = 32'h04;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      run_fetch(seq[i], 1, h0, d0, n, ok, h1, d1);
      vectors++;
      if (h0 !== 1'b0 || n != 2) begin
        errors++; $display("FAIL conflict_miss %0d: got hit=%b n=%0d want 0/2", i, h0, n);
      end
    end
    vectors++;
    if (d1 !== mem_fn(32'h04) || h1 !== 1'b1) begin
      errors++; $display("FAIL conflict_data: got %b/%h want 1/%h", h1, d1, mem_fn(32'h04));
    end
    vectors++;
    if (bus.miss_count !== 32'd3) begin
      errors++; $display("FAIL conflict_count: got %0d want 3", bus.miss_count);
    end
  endtask

  task automatic test_flush();
    logic h0, h1, ok; logic [31:0] d0, d1; int n;
    do_reset();
    run_fetch(32'h0, 0, h0, d0, n, ok, h1, d1);
    @(negedge clk);
    bus.flush = 1'b1; #1;
    vectors++;
    if (bus.ihit !== 1'b0) begin errors++; $display("FAIL flush_ihit: got %b want 0", bus.ihit); end
    // Flush while memory is still busy.
    @(negedge clk);
    bus.flush = 1'b0; bus.imemaddr = 32'h10; lat = 100;
    repeat (2) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0; bus.imemREN = 1'b0; #1;
    vectors++;
    if (bus.iREN !== 1'b0 || bus.miss_count !== 32'd1) begin
      errors++; $display("FAIL flush_busy: got iren=%b count=%0d want 0/1", bus.iREN,
                         bus.miss_count);
    end
    // Flush in the same cycle the memory answers.
    @(negedge clk);
    bus.imemREN = 1'b1; lat = 2;
    repeat (3) @(negedge clk);
    bus.flush = 1'b1; #1;
    vectors++;
    if (bus.iREN !== 1'b1 || bus.iwait !== 1'b0) begin
      errors++; $display("FAIL flush_setup: got iren=%b iwait=%b want 1/0", bus.iREN, bus.iwait);
    end
    @(negedge clk);
    bus.flush = 1'b0; bus.imemREN = 1'b0; #1;
    vectors++;
    if (bus.iREN !== 1'b0 || bus.miss_count !== 32'd1) begin
      errors++; $display("FAIL flush_wins: got iren=%b count=%0d want 0/1", bus.iREN,
                         bus.miss_count);
    end
    run_fetch(32'h10, 0, h0, d0, n, ok, h1, d1);
    vectors++;
    if (h0 !== 1'b0 || h1 !== 1'b1 || d1 !== mem_fn(32'h10) || bus.miss_count !== 32'd2) begin
      errors++; $display("FAIL flush_refetch: got %b/%b/%h cnt=%0d want 0/1/%h cnt=2", h0, h1, d1,
                         bus.miss_count, mem_fn(32'h10));
    end
  endtask

  task automatic test_async_reset();
    logic h0, h1, ok; logic [31:0] d0, d1; int n;
    do_reset();
    run_fetch(32'h0, 0, h0, d0, n, ok, h1, d1);
    @(negedge clk);
    bus.imemaddr = 32'h08; lat = 100;
    repeat (2) @(negedge clk);
    #3;
    rst = 1'b1; #1;
    vectors++;
    if (bus.iREN !== 1'b0 || bus.miss_count !== 32'd0) begin
      errors++; $display("FAIL arst_now: got iren=%b count=%0d want 0/0", bus.iREN,
                         bus.miss_count);
    end
    @(negedge clk);
    rst = 1'b0; bus.imemREN = 1'b0;
    run_fetch(32'h0, 0, h0, d0, n, ok, h1, d1);
    vectors++;
    if (h0 !== 1'b0 || h1 !== 1'b1) begin
      errors++; $display("FAIL arst_invalid: got first=%b after=%b want 0/1", h0, h1);
    end
  endtask

  task automatic test_addr_change();
    logic h0, h1, ok; logic [31:0] d0, d1; int n;
    do_reset();
    run_fetch(32'h04, 0, h0, d0, n, ok, h1, d1);
    @(negedge clk);
    bus.imemaddr = 32'h20; lat = 3;
    @(negedge clk);
    @(negedge clk);
    bus.imemaddr = 32'h04; #1;
    vectors++;
    if (bus.ihit !== 1'b1 || bus.imemload !== mem_fn(32'h04) || bus.iREN !== 1'b1 ||
        bus.iaddr !== 32'h20) begin
      errors++; $display("FAIL chg_hit: got %b/%h iren=%b iaddr=%h want 1/%h 1/00000020",
                         bus.ihit, bus.imemload, bus.iREN, bus.iaddr, mem_fn(32'h04));
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (!bus.iREN) break;
    end
    vectors++;
    if (bus.iREN !== 1'b0) begin errors++; $display("FAIL chg_done: got iren=%b want 0", bus.iREN); end
    run_fetch(32'h20, 0, h0, d0, n, ok, h1, d1);
    vectors++;
    if (h0 !== 1'b1 || d0 !== mem_fn(32'h20) || bus.miss_count !== 32'd2) begin
      errors++; $display("FAIL chg_fill: got %b/%h cnt=%0d want 1/%h cnt=2", h0, d0,
                         bus.miss_count, mem_fn(32'h20));
    end
  endtask

  task automatic test_random();
    logic h0, h1, ok, eh; logic [31:0] d0, d1, a; int n, l;
    do_reset();
    for (int it = 0; it < 60; it++) begin
      a  = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom)};
      a  = a | (($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'h0);
      l  = $urandom_range(0, 3);
      eh = model_hit(a);
      run_fetch(a, l, h0, d0, n, ok, h1, d1);
      vectors++;
      if (h0 !== eh || (eh && d0 !== mem_fn(a))) begin
        errors++; $display("FAIL rnd_hit a=%h: got %b/%h want %b/%h", a, h0, d0, eh, mem_fn(a));
      end
      if (!eh) begin
        model_fill(a);
        vectors++;
        if (n != l + 1 || !ok || h1 !== 1'b1 || d1 !== mem_fn(a)) begin
          errors++; $display("FAIL rnd_fill a=%h: got n=%0d ok=%b %b/%h want %0d/1/1/%h", a, n,
                             ok, h1, d1, l + 1, mem_fn(a));
        end
      end
      vectors++;
      if (bus.miss_count !== 32'(exp_count)) begin
        errors++; $display("FAIL rnd_count: got %0d want %0d", bus.miss_count, exp_count);
      end
      if ($urandom_range(0, 9) == 0) begin
        @(negedge clk);
        bus.imemREN = 1'b0; #1;
        vectors++;
        if (bus.ihit !== 1'b0) begin errors++; $display("FAIL rnd_noreq: got %b want 0", bus.ihit); end
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        model_clear();
      end
    end
  endtask

  initial begin
    vectors = 0; errors = 0; exp_count = 0; lat = 0;
    rst = 1'b1; bus.flush = 1'b0; bus.imemREN = 1'b0; bus.imemaddr = '0;
    model_clear();
    test_reset();
    test_miss_latency();
    test_sequential();
    test_conflict();
    test_flush();
    test_async_reset();
    test_addr_change();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1);
  end
endmodule
